priority_encoder: RTL and testbench
===================================

# priority_encoder

Parameterised highest-priority encoder: reports the index of the most-significant set bit of an input request vector, plus a valid flag. The primary `y`/`valid` path is purely combinational. A registered copy of the result is provided for pipelined consumers such as arbiters and interrupt controllers. It is a leaf block used wherever a request vector must be reduced to a single winning index.

## Interface
Parameters:
- `WIDTH`, default 4: number of request inputs; legal values are ≥ 2.
- `IW`, default `$clog2(WIDTH)`: index width, 2 at the default. Derived; do not override.

Ports. Declaration order is `y, valid, a, clk, reset`, so positional 3-port instantiation `(y, valid, a)` remains legal.
- `clk`  input  1  sole clock; all registers on rising edge.
- `reset`  input  1  asynchronous, active-high; clears all registered outputs.
- `y`  output  IW  combinational index of the highest set bit of `a`.
- `valid`  output  1  combinational; 1 iff `a != 0`.
- `a`  input  WIDTH  request vector; bit `WIDTH-1` has highest priority.
- `onehot`  output  WIDTH  combinational one-hot of the winning bit; all-zero when `a == 0`.
- `y_q`  output  IW  registered `y`.
- `valid_q`  output  1  registered `valid`.
- `onehot_q`  output  WIDTH  registered `onehot`.

## Operation
- `y` is the largest `i` such that `a[i] == 1`. Lower set bits are ignored.
- When `a == 0`: `y = 0`, `valid = 0`, `onehot = 0`. `y` is therefore ambiguous between `a = 0` and `a = 1`; consumers must qualify `y` with `valid`.
- Reference mapping for `WIDTH = 4`:
  - `a` 0 → `y` 0, `valid` 0
  - `a` 1 → `y` 0, `valid` 1
  - `a` 2–3 → `y` 1, `valid` 1
  - `a` 4–7 → `y` 2, `valid` 1
  - `a` 8–15 → `y` 3, `valid` 1
- `onehot = valid ? (1 << y) : 0`.
- Implementation must be generic in `WIDTH`: a loop-based scan from LSB to MSB with last-hit-wins, or an equivalent scan. No hard-coded case table.
- No X propagation for any fully-defined `a`.

## Timing
- Combinational outputs (`y`, `valid`, `onehot`): zero-cycle latency. They must settle within one simulation delta plus gate delay; benches sample 10 ps after applying `a`.
- Registered outputs: one-cycle latency. `y_q`, `valid_q` and `onehot_q` on edge N+1 equal the combinational values for `a` sampled at edge N.
- Reset behaviour:
  - Reset values: `y_q = 0`, `valid_q = 0`, `onehot_q = 0`.
  - `reset` asserted at any time clears the registered outputs immediately, without waiting for `clk`.
  - Reset does not affect the combinational outputs.
  - On the first rising edge after `reset` deasserts, the registered outputs capture the current `a`.
- No enable: the registered outputs update on every clock.

## Structure
- No shared package required. `IW` is a localparam derived from `WIDTH` inside the module.
- Natural sub-module: `priority_encoder_core`, the purely combinational scan producing `y`/`valid`/`onehot`.
  - The top level instantiates the core once and adds the output register stage with async reset.

## Test plan
- Exhaustive combinational sweep, `WIDTH = 4`: `a` = 0..15, check after 10 ps.
  - `y` must match {0,0,1,1,2,2,2,2,3,3,3,3,3,3,3,3}.
  - `valid` must be 0 for `a = 0` and 1 otherwise.
- Onehot check: `a = 4'b0110` → `onehot = 4'b0100`; `a = 0` → `onehot = 0`.
- Pipeline latency: drive `a = 8` before edge N → at edge N+1, `y_q = 3` and `valid_q = 1`; change `a` to 1 before edge N+1 → at edge N+2, `y_q = 0` and `valid_q = 1`.
- Async reset mid-operation: with `valid_q = 1`, assert `reset` between edges → `y_q`, `valid_q` and `onehot_q` go to 0 before the next edge; `y`/`valid` are unaffected.
- Parameter scaling, `WIDTH = 8`:
  - `a = 8'h80` → `y = 7`.
  - `a = 8'h01` → `y = 0`, `valid = 1`.
  - `a = 8'h3C` → `y = 5`.

Source files
------------

// File: rtl/priority_encoder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | priority_encoder_pkg                                                 |
// | Shared constants and helpers for the priority encoder slice.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package priority_encoder_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Index width for a request vector of w bits; w >= 2 is always legal,
  // the guard keeps a degenerate width from producing a zero-width bus.
  function automatic int pe_index_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/priority_encoder_core.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | priority_encoder_core                                                |
// | Purely combinational highest-set-bit scan.                           |
// | Revision: 1.0                                                        |
// |                                                                      |
// | Ports:                                                               |
// |   a_i      [WIDTH-1:0] request vector, MSB has highest priority      |
// |   y_o      [IW-1:0]    index of highest set bit (0 when a_i == 0)    |
// |   valid_o              1 iff a_i != 0                                |
// |   onehot_o [WIDTH-1:0] one-hot of the winning bit, 0 when idle       |
// +----------------------------------------------------------------------+
module priority_encoder_core
  import priority_encoder_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int IW    = pe_index_width(WIDTH)
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [IW-1:0]    y_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] onehot_o
);

  // LSB-to-MSB scan: every hit overwrites the previous one, so the last
  // (most significant) set bit is what remains at the end of the loop.
  always_comb begin
    y_o      = '0;
    valid_o  = 1'b0;
    onehot_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (a_i[i]) begin
        y_o         = IW'(i);
        valid_o     = 1'b1;
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/priority_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | priority_encoder                                                     |
// | Highest-priority encoder with combinational result and a registered  |
// | copy for pipelined consumers.                                        |
// | Revision: 1.0                                                        |
// |                                                                      |
// | Ports:                                                               |
// |   y        [IW-1:0]    combinational index of highest set bit of a   |
// |   valid                combinational, 1 iff a != 0                   |
// |   a        [WIDTH-1:0] request vector, bit WIDTH-1 highest priority  |
// |   clk                  rising-edge clock for the output registers    |
// |   reset                asynchronous active-high, clears *_q outputs  |
// |   onehot   [WIDTH-1:0] combinational one-hot of the winning bit      |
// |   y_q, valid_q, onehot_q  the above, registered one cycle later      |
// +----------------------------------------------------------------------+
module priority_encoder
  import priority_encoder_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int IW    = pe_index_width(WIDTH)
) (
  output logic [IW-1:0]    y,
  output logic             valid,
  input  logic [WIDTH-1:0] a,
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] onehot,
  output logic [IW-1:0]    y_q,
  output logic             valid_q,
  output logic [WIDTH-1:0] onehot_q
);

  logic [IW-1:0]    y_d;
  logic             valid_d;
  logic [WIDTH-1:0] onehot_d;

  priority_encoder_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i      (a),
    .y_o      (y_d),
    .valid_o  (valid_d),
    .onehot_o (onehot_d)
  );

  // Combinational outputs bypass the register stage and ignore reset.
  assign y      = y_d;
  assign valid  = valid_d;
  assign onehot = onehot_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q      <= '0;
      valid_q  <= 1'b0;
      onehot_q <= '0;
    end else begin
      y_q      <= y_d;
      valid_q  <= valid_d;
      onehot_q <= onehot_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_priority_encoder                                                  |
// | Self-checking bench for priority_encoder at WIDTH = 4 and WIDTH = 8. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_priority_encoder;

  logic clk;
  logic reset;

  logic [3:0] a4;
  logic [1:0] y4, y4_q;
  logic       v4, v4_q;
  logic [3:0] oh4, oh4_q;

  logic [7:0] a8;
  logic [2:0] y8, y8_q;
  logic       v8, v8_q;
  logic [7:0] oh8, oh8_q;

  int n_checks = 0;
  int n_pass   = 0;

  priority_encoder #(.WIDTH(4)) dut4 (
    .y(y4), .valid(v4), .a(a4), .clk(clk), .reset(reset),
    .onehot(oh4), .y_q(y4_q), .valid_q(v4_q), .onehot_q(oh4_q)
  );

  priority_encoder #(.WIDTH(8)) dut8 (
    .y(y8), .valid(v8), .a(a8), .clk(clk), .reset(reset),
    .onehot(oh8), .y_q(y8_q), .valid_q(v8_q), .onehot_q(oh8_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: index of highest set bit is floor(log2(a)), which equals
  // clog2(a+1)-1 for any a > 0; zero input maps to index 0.
  function automatic int ref_idx(input int unsigned av);
    return (av == 0) ? 0 : $clog2(av + 1) - 1;
  endfunction

  function automatic int unsigned ref_oh(input int unsigned av);
    return (av == 0) ? 0 : (32'd1 << ref_idx(av));
  endfunction

  typedef struct {
    logic [3:0] a;
    logic [1:0] y;
    logic       v;
    logic [3:0] oh;
  } vec_t;

  vec_t vecs[16];
  int   ytab[16] = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};
  logic [3:0] oh_tab[16] = '{4'h0, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4, 4'h4,
                             4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8};

  initial begin
    int unsigned exp_a4, exp_a8;

    for (int i = 0; i < 16; i++) begin
      vecs[i].a  = 4'(i);
      vecs[i].y  = 2'(ytab[i]);
      vecs[i].v  = (i != 0);
      vecs[i].oh = oh_tab[i];
    end

    // ---------------- reset state ----------------
    reset = 1'b1;
    a4 = 4'h0;
    a8 = 8'h0;
    repeat (2) @(posedge clk);
    #0.01;
    chk("rst_y_q", 32'(y4_q), 0);
    chk("rst_valid_q", 32'(v4_q), 0);
    chk("rst_onehot_q", 32'(oh4_q), 0);
    // Reset held: registers must not capture a nonzero request.
    a4 = 4'hF;
    @(posedge clk);
    #0.01;
    chk("rst_hold_valid_q", 32'(v4_q), 0);
    chk("rst_comb_y", 32'(y4), 3);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #0.01;
    chk("first_edge_y_q", 32'(y4_q), 3);
    chk("first_edge_valid_q", 32'(v4_q), 1);

    // ---------------- exhaustive WIDTH=4 table ----------------
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a4 = vecs[i].a;
      #0.01;
      chk($sformatf("tab_y[%0d]", i), 32'(y4), 32'(vecs[i].y));
      chk($sformatf("tab_valid[%0d]", i), 32'(v4), 32'(vecs[i].v));
      chk($sformatf("tab_onehot[%0d]", i), 32'(oh4), 32'(vecs[i].oh));
    end

    // onehot spot checks
    a4 = 4'b0110; #0.01;
    chk("onehot_0110", 32'(oh4), 32'h4);
    a4 = 4'b0000; #0.01;
    chk("onehot_zero", 32'(oh4), 32'h0);

    // ---------------- pipeline latency ----------------
    @(negedge clk);
    a4 = 4'd8;
    @(posedge clk);       // edge N samples 8
    #0.01;
    chk("pipe_n_y_q", 32'(y4_q), 3);
    chk("pipe_n_valid_q", 32'(v4_q), 1);
    a4 = 4'd1;
    @(posedge clk);       // edge N+1 samples 1
    #0.01;
    chk("pipe_n1_y_q", 32'(y4_q), 0);
    chk("pipe_n1_valid_q", 32'(v4_q), 1);
    chk("pipe_n1_onehot_q", 32'(oh4_q), 1);

    // ---------------- async reset mid-cycle ----------------
    a4 = 4'd8;
    @(posedge clk);
    #0.01;
    chk("arst_pre_valid_q", 32'(v4_q), 1);
    #2;
    reset = 1'b1;
    #0.01;
    chk("arst_y_q", 32'(y4_q), 0);
    chk("arst_valid_q", 32'(v4_q), 0);
    chk("arst_onehot_q", 32'(oh4_q), 0);
    chk("arst_comb_y", 32'(y4), 3);
    chk("arst_comb_valid", 32'(v4), 1);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #0.01;
    chk("arst_recover_y_q", 32'(y4_q), 3);

    // ---------------- WIDTH=8 scaling ----------------
    @(negedge clk);
    a8 = 8'h80; #0.01;
    chk("w8_80_y", 32'(y8), 7);
    a8 = 8'h01; #0.01;
    chk("w8_01_y", 32'(y8), 0);
    chk("w8_01_valid", 32'(v8), 1);
    a8 = 8'h3C; #0.01;
    chk("w8_3c_y", 32'(y8), 5);
    chk("w8_3c_onehot", 32'(oh8), 32'h20);

    // ---------------- randomized vs reference model ----------------
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      a4 = 4'($urandom_range(0, 15));
      // Bias toward sparse patterns so low indices are exercised too.
      a8 = (k % 3 == 0) ? 8'($urandom) : 8'(8'h1 << $urandom_range(0, 7)) | 8'($urandom_range(0, 3));
      if (k % 17 == 0) a8 = 8'h0;
      #0.01;
      chk("rnd4_y", 32'(y4), 32'(ref_idx(32'(a4))));
      chk("rnd4_valid", 32'(v4), 32'(a4 != 0));
      chk("rnd8_y", 32'(y8), 32'(ref_idx(32'(a8))));
      chk("rnd8_valid", 32'(v8), 32'(a8 != 0));
      chk("rnd8_onehot", 32'(oh8), ref_oh(32'(a8)));
      exp_a4 = 32'(a4);
      exp_a8 = 32'(a8);
      @(posedge clk);
      #0.01;
      chk("rnd4_y_q", 32'(y4_q), 32'(ref_idx(exp_a4)));
      chk("rnd4_onehot_q", 32'(oh4_q), ref_oh(exp_a4));
      chk("rnd8_y_q", 32'(y8_q), 32'(ref_idx(exp_a8)));
      chk("rnd8_valid_q", 32'(v8_q), 32'(exp_a8 != 0));
      chk("rnd8_onehot_q", 32'(oh8_q), ref_oh(exp_a8));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
